whitening_sequencer: RTL and testbench

Single-clock sequencer for the whitening datapath: ROM -> Centering -> RAM1 -> Covariance -> QR_decomposition -> Eigen_Conditioning_Block -> Whitening_Multiplier1 -> Whitening_Multiplier2 -> RAM2. It drives clock enables, GO pulses, read/write selects and sample addresses in place of gated clocks. It waits on each stage's busy handshake with a timeout, and reports busy, done and error to the top level.

---
 rtl/whitening_pkg.sv | 43 ++++
 rtl/busy_handshake.sv | 32 +++
 rtl/whitening_sequencer.sv | 146 ++++++++++++++
 tb/tb_whitening_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/whitening_pkg.sv
// whitening_pkg: state codes, control-word layout and shared constants for the whitening sequencer
package whitening_pkg;
  localparam int ADDR_W_DEF = 14;
  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    CEN_LOAD = 4'd1,
    CEN_WAIT = 4'd2,
    STORE    = 4'd3,
    COV      = 4'd4,
    COV_WAIT = 4'd5,
    QR       = 4'd6,
    QR_WAIT  = 4'd7,
    EIG      = 4'd8,
    MULT1    = 4'd9,
    MULT2    = 4'd10,
    DONE     = 4'd11
  } state_t;

  typedef struct packed {
    logic en_mem1;
    logic en_mem2;
    logic en_mem3;
    logic r_w1;
    logic r_w2;
    logic go_cen;
    logic go_cov;
    logic go_qr;
    logic en_eig;
    logic en_multi_1;
    logic en_multi_2;
    logic busy;
    logic done;
  } ctrl_t;

  localparam ctrl_t CTRL_RST = '{r_w1: RD, r_w2: RD, default: 1'b0};

  function automatic logic is_wait(state_t s);
    return s inside {CEN_WAIT, COV_WAIT, QR_WAIT};
  endfunction
endpackage

// File: rtl/busy_handshake.sv
// busy_handshake: waits for a stage's busy to rise then fall, flagging a timeout if it never rises
module busy_handshake #(
  parameter int BUSY_TO = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_restart,
  input  logic i_busy,
  output logic o_done,
  output logic o_timeout
);
  localparam int CW = $clog2(BUSY_TO + 1);

  logic          r_seen;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_seen <= 1'b0;
      r_cnt  <= '0;
    end else if (i_restart) begin
      r_seen <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_seen <= r_seen | i_busy;
      r_cnt  <= r_seen ? r_cnt : r_cnt + 1'b1;
    end

  // busy already high on entry moves straight to the fall watch
  assign o_done    = ~i_restart & r_seen & ~i_busy;
  assign o_timeout = ~i_restart & ~r_seen & ~i_busy & (r_cnt == CW'(BUSY_TO - 1));
endmodule

// File: rtl/whitening_sequencer.sv
// whitening_sequencer: steps the whitening pipeline via enables, GO pulses and sample addresses
module whitening_sequencer
  import whitening_pkg::*;
#(
  parameter int N_SAMPLES = 16384,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int RD_LAT    = 1,
  parameter int M2_LAT    = 2,
  parameter int EIG_CYC   = 4,
  parameter int M1_CYC    = 4,
  parameter int BUSY_TO   = 255
) (
  input  logic              CLK_whitening,
  input  logic              RST_whitening,
  input  logic              GO_whitening,
  input  logic              New_one,
  input  logic              CEN_busy,
  input  logic              COV_busy,
  input  logic              QR_busy,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] addr_wr,
  output logic              En_mem1,
  output logic              En_mem2,
  output logic              En_mem3,
  output logic              R_w1,
  output logic              R_w2,
  output logic              GO_cen,
  output logic              GO_cov,
  output logic              GO_QR,
  output logic              En_eig,
  output logic              En_multi_1,
  output logic              En_multi_2,
  output logic              Whitening_busy,
  output logic              Whitening_done,
  output logic              Whitening_err,
  output logic [3:0]        state
);
  localparam int CW = ADDR_W + 1;
  localparam int LAT = RD_LAT + M2_LAT;
  localparam logic [CW-1:0] LAST = CW'(N_SAMPLES - 1);

  state_t            r_state, w_nxt;
  logic [CW-1:0]     r_cnt, w_cnt;
  logic              r_err, w_err, w_end;
  ctrl_t             r_ctrl, w_ctrl;
  logic [ADDR_W-1:0] r_addr, r_addr_wr, w_addr, w_addr_wr;
  logic              w_hs_busy, w_hs_done, w_hs_to;
  logic              w_m2_rd, w_m2_wr, w_sweep;

  assign w_hs_busy = (r_state == CEN_WAIT) ? CEN_busy : (r_state == COV_WAIT) ? COV_busy : QR_busy;

  busy_handshake #(.BUSY_TO(BUSY_TO)) u_hs (
    .i_clk    (CLK_whitening),
    .i_rst    (RST_whitening),
    .i_restart(!is_wait(r_state)),
    .i_busy   (w_hs_busy),
    .o_done   (w_hs_done),
    .o_timeout(w_hs_to)
  );

  always_comb begin
    w_end = 1'b1;
    case (r_state)
      IDLE:                        w_end = GO_whitening;
      CEN_LOAD, STORE, COV:        w_end = r_cnt == LAST;
      CEN_WAIT, COV_WAIT, QR_WAIT: w_end = w_hs_done;
      EIG:                         w_end = r_cnt == CW'(EIG_CYC - 1);
      MULT1:                       w_end = r_cnt == CW'(M1_CYC - 1);
      MULT2:                       w_end = r_cnt == CW'(N_SAMPLES + LAT - 1);
      default:                     w_end = 1'b1;
    endcase
    w_nxt = w_end ? ((r_state == DONE) ? IDLE : state_t'(r_state + 4'd1)) : r_state;
    w_cnt = (w_end || r_state == IDLE) ? '0 : r_cnt + 1'b1;
    w_err = (r_state == IDLE && GO_whitening) ? 1'b0 : r_err;
    if (w_hs_to) begin
      w_nxt = IDLE;
      w_err = 1'b1;
    end
    // abort outranks both timeout and normal advance
    if (New_one && r_state != IDLE) begin
      w_nxt = CEN_LOAD;
      w_cnt = '0;
      w_err = r_err;
    end
  end

  // outputs are decoded from the next state/count so every port comes straight off a flop
  assign w_m2_rd = w_cnt < CW'(N_SAMPLES);
  assign w_m2_wr = w_cnt >= CW'(LAT);
  assign w_sweep = w_nxt inside {CEN_LOAD, STORE, COV};

  always_comb begin
    w_ctrl            = CTRL_RST;
    w_ctrl.en_mem1    = w_nxt inside {CEN_LOAD, STORE};
    w_ctrl.en_mem2    = w_nxt inside {STORE, COV} || (w_nxt == MULT2 && w_m2_rd);
    w_ctrl.en_mem3    = w_nxt == MULT2 && w_m2_wr;
    w_ctrl.r_w1       = (w_nxt == STORE) ? WR : RD;
    w_ctrl.r_w2       = w_ctrl.en_mem3 ? WR : RD;
    w_ctrl.go_cen     = w_nxt == CEN_LOAD && w_cnt == '0;
    w_ctrl.go_cov     = w_nxt == COV && w_cnt == '0;
    w_ctrl.go_qr      = w_nxt == QR;
    w_ctrl.en_eig     = w_nxt == EIG;
    w_ctrl.en_multi_1 = w_nxt == MULT1;
    w_ctrl.en_multi_2 = w_nxt == MULT2;
    w_ctrl.busy       = w_nxt != IDLE;
    w_ctrl.done       = w_nxt == DONE;
    w_addr            = (w_nxt == MULT2 && !w_m2_rd) ? LAST[ADDR_W-1:0] :
                        (w_sweep || w_nxt == MULT2) ? w_cnt[ADDR_W-1:0] : '0;
    w_addr_wr         = w_ctrl.en_mem3 ? ADDR_W'(w_cnt - CW'(LAT)) : '0;
  end

  always_ff @(posedge CLK_whitening or posedge RST_whitening)
    if (RST_whitening) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_ctrl    <= CTRL_RST;
      r_addr    <= '0;
      r_addr_wr <= '0;
    end else begin
      r_state   <= w_nxt;
      r_cnt     <= w_cnt;
      r_err     <= w_err;
      r_ctrl    <= w_ctrl;
      r_addr    <= w_addr;
      r_addr_wr <= w_addr_wr;
    end

  assign addr           = r_addr;
  assign addr_wr        = r_addr_wr;
  assign En_mem1        = r_ctrl.en_mem1;
  assign En_mem2        = r_ctrl.en_mem2;
  assign En_mem3        = r_ctrl.en_mem3;
  assign R_w1           = r_ctrl.r_w1;
  assign R_w2           = r_ctrl.r_w2;
  assign GO_cen         = r_ctrl.go_cen;
  assign GO_cov         = r_ctrl.go_cov;
  assign GO_QR          = r_ctrl.go_qr;
  assign En_eig         = r_ctrl.en_eig;
  assign En_multi_1     = r_ctrl.en_multi_1;
  assign En_multi_2     = r_ctrl.en_multi_2;
  assign Whitening_busy = r_ctrl.busy;
  assign Whitening_done = r_ctrl.done;
  assign Whitening_err  = r_err;
  assign state          = r_state;
endmodule

// File: tb/tb_whitening_sequencer.sv
// tb_whitening_sequencer: directed table run plus timeout, abort, reset and full-width sweep sequences
module tb_whitening_sequencer;
  import whitening_pkg::*;

  localparam int N  = 4;
  localparam int AW = 14;
  localparam int TO = 255;

  // control word: m1 m2 m3 rw1 rw2 gocen gocov goqr eig mul1 mul2 busy done
  localparam logic [12:0] LD0 = 13'b1_0_0_1_1_1_0_0_0_0_0_1_0;
  localparam logic [12:0] LD  = 13'b1_0_0_1_1_0_0_0_0_0_0_1_0;
  localparam logic [12:0] WT  = 13'b0_0_0_1_1_0_0_0_0_0_0_1_0;
  localparam logic [12:0] ST  = 13'b1_1_0_0_1_0_0_0_0_0_0_1_0;
  localparam logic [12:0] CV0 = 13'b0_1_0_1_1_0_1_0_0_0_0_1_0;
  localparam logic [12:0] CV  = 13'b0_1_0_1_1_0_0_0_0_0_0_1_0;
  localparam logic [12:0] QRC = 13'b0_0_0_1_1_0_0_1_0_0_0_1_0;
  localparam logic [12:0] EG  = 13'b0_0_0_1_1_0_0_0_1_0_0_1_0;
  localparam logic [12:0] M1C = 13'b0_0_0_1_1_0_0_0_0_1_0_1_0;
  localparam logic [12:0] M2R = 13'b0_1_0_1_1_0_0_0_0_0_1_1_0;
  localparam logic [12:0] M2B = 13'b0_1_1_1_0_0_0_0_0_0_1_1_0;
  localparam logic [12:0] M2W = 13'b0_0_1_1_0_0_0_0_0_0_1_1_0;
  localparam logic [12:0] DN  = 13'b0_0_0_1_1_0_0_0_0_0_0_1_1;
  localparam logic [12:0] ID  = 13'b0_0_0_1_1_0_0_0_0_0_0_0_0;

  typedef struct {
    logic [2:0]    busy;
    logic [3:0]    st;
    logic [AW-1:0] a;
    logic [AW-1:0] aw;
    logic [12:0]   c;
  } vec_t;

  vec_t vt[$];
  int   n_chk = 0;
  int   n_fail = 0;

  logic clk = 0, rst = 1, go = 0, new_one = 0, go_big = 0, zero = 0;
  logic auto_b = 0, qr_dead = 0;
  logic t_cen = 0, t_cov = 0, t_qr = 0;
  int   g_cen = 1000, g_cov = 1000, g_qr = 1000;
  logic cen_b, cov_b, qr_b;

  logic [AW-1:0] addr, addr_wr, b_addr, b_addr_wr;
  logic En_mem1, En_mem2, En_mem3, R_w1, R_w2, GO_cen, GO_cov, GO_QR;
  logic En_eig, En_multi_1, En_multi_2, busy, done, err;
  logic [3:0] state, b_state;
  logic b_m1, b_m2, b_m3, b_rw1, b_rw2, b_gcen, b_gcov, b_gqr, b_eig, b_mu1, b_mu2, b_busy, b_done, b_err;
  logic [12:0] ctrl;

  always #5 clk = ~clk;

  // stage models: busy rises 2 cycles after the GO pulse and stays high for 5 cycles
  always @(negedge clk) begin
    g_cen = GO_cen ? 0 : (g_cen < 1000 ? g_cen + 1 : g_cen);
    g_cov = GO_cov ? 0 : (g_cov < 1000 ? g_cov + 1 : g_cov);
    g_qr  = GO_QR  ? 0 : (g_qr  < 1000 ? g_qr  + 1 : g_qr);
  end
  assign cen_b = auto_b ? (g_cen >= 2 && g_cen <= 6) : t_cen;
  assign cov_b = auto_b ? (g_cov >= 2 && g_cov <= 6) : t_cov;
  assign qr_b  = auto_b ? (!qr_dead && g_qr >= 2 && g_qr <= 6) : t_qr;

  assign ctrl = {En_mem1, En_mem2, En_mem3, R_w1, R_w2, GO_cen, GO_cov, GO_QR,
                 En_eig, En_multi_1, En_multi_2, busy, done};

  whitening_sequencer #(.N_SAMPLES(N), .ADDR_W(AW), .BUSY_TO(TO)) dut (
    .CLK_whitening(clk), .RST_whitening(rst), .GO_whitening(go), .New_one(new_one),
    .CEN_busy(cen_b), .COV_busy(cov_b), .QR_busy(qr_b),
    .addr(addr), .addr_wr(addr_wr), .En_mem1(En_mem1), .En_mem2(En_mem2), .En_mem3(En_mem3),
    .R_w1(R_w1), .R_w2(R_w2), .GO_cen(GO_cen), .GO_cov(GO_cov), .GO_QR(GO_QR),
    .En_eig(En_eig), .En_multi_1(En_multi_1), .En_multi_2(En_multi_2),
    .Whitening_busy(busy), .Whitening_done(done), .Whitening_err(err), .state(state)
  );

  whitening_sequencer #(.N_SAMPLES(1 << AW), .ADDR_W(AW), .BUSY_TO(TO)) dut_big (
    .CLK_whitening(clk), .RST_whitening(rst), .GO_whitening(go_big), .New_one(zero),
    .CEN_busy(zero), .COV_busy(zero), .QR_busy(zero),
    .addr(b_addr), .addr_wr(b_addr_wr), .En_mem1(b_m1), .En_mem2(b_m2), .En_mem3(b_m3),
    .R_w1(b_rw1), .R_w2(b_rw2), .GO_cen(b_gcen), .GO_cov(b_gcov), .GO_QR(b_gqr),
    .En_eig(b_eig), .En_multi_1(b_mu1), .En_multi_2(b_mu2),
    .Whitening_busy(b_busy), .Whitening_done(b_done), .Whitening_err(b_err), .state(b_state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] b, input logic [3:0] s, input int a, input int aw, input logic [12:0] c);
    vt.push_back('{b, s, AW'(a), AW'(aw), c});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [3:0] s, input int bound, input string name);
    int k = 0;
    while (state !== s && k < bound) begin
      step();
      k++;
    end
    chk(name, state, s);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, nd, bad;
    logic [AW-1:0] last;
    // one full run with N=4: per-cycle busy inputs and expected outputs from CEN_LOAD entry
    add(3'b000, CEN_LOAD, 0, 0, LD0);
    for (int i = 1; i < 4; i++) add(i >= 2 ? 3'b100 : 3'b000, CEN_LOAD, i, 0, LD);
    for (int i = 4; i < 8; i++) add(i < 7 ? 3'b100 : 3'b000, CEN_WAIT, 0, 0, WT);
    for (int i = 0; i < 4; i++) add(3'b000, STORE, i, 0, ST);
    add(3'b000, COV, 0, 0, CV0);
    for (int i = 1; i < 4; i++) add(i >= 2 ? 3'b010 : 3'b000, COV, i, 0, CV);
    for (int i = 16; i < 20; i++) add(i < 19 ? 3'b010 : 3'b000, COV_WAIT, 0, 0, WT);
    add(3'b000, QR, 0, 0, QRC);
    for (int i = 21; i < 28; i++) add((i >= 22 && i <= 26) ? 3'b001 : 3'b000, QR_WAIT, 0, 0, WT);
    for (int i = 0; i < 4; i++) add(3'b000, EIG, 0, 0, EG);
    for (int i = 0; i < 4; i++) add(3'b000, MULT1, 0, 0, M1C);
    add(3'b000, MULT2, 0, 0, M2R);
    add(3'b000, MULT2, 1, 0, M2R);
    add(3'b000, MULT2, 2, 0, M2R);
    add(3'b000, MULT2, 3, 0, M2B);
    add(3'b000, MULT2, 3, 1, M2W);
    add(3'b000, MULT2, 3, 2, M2W);
    add(3'b000, MULT2, 3, 3, M2W);
    add(3'b000, DONE, 0, 0, DN);
    add(3'b000, IDLE, 0, 0, ID);

    repeat (2) @(posedge clk);
    #1;
    chk("reset.state", state, IDLE);
    chk("reset.ctrl", ctrl, ID);
    chk("reset.addr", addr, 0);
    chk("reset.addr_wr", addr_wr, 0);
    chk("reset.err", err, 0);
    rst = 0;
    step();
    go = 1;
    step();
    go = 0;
    foreach (vt[i]) begin
      {t_cen, t_cov, t_qr} = vt[i].busy;
      chk($sformatf("run[%0d].state", i), state, vt[i].st);
      chk($sformatf("run[%0d].addr", i), addr, vt[i].a);
      chk($sformatf("run[%0d].addr_wr", i), addr_wr, vt[i].aw);
      chk($sformatf("run[%0d].ctrl", i), ctrl, vt[i].c);
      step();
    end
    chk("run.err", err, 0);

    // QR never answers: timeout lands in IDLE with a sticky error
    auto_b = 1;
    qr_dead = 1;
    go = 1;
    step();
    go = 0;
    wait_state(QR, 100, "to.reach_qr");
    k = 0;
    while (err !== 1'b1 && k < 400) begin
      step();
      k++;
    end
    chk("to.cycles", k, TO + 1);
    chk("to.state", state, IDLE);
    chk("to.busy", busy, 0);
    repeat (5) step();
    chk("to.sticky", err, 1);
    qr_dead = 0;
    go = 1;
    step();
    go = 0;
    chk("to.err_cleared", err, 0);
    chk("to.restart_state", state, CEN_LOAD);

    // abort during QR_WAIT restarts the load from address 0
    wait_state(QR_WAIT, 100, "abort.reach_qrwait");
    new_one = 1;
    step();
    new_one = 0;
    chk("abort.state", state, CEN_LOAD);
    chk("abort.addr", addr, 0);
    chk("abort.go_cen", GO_cen, 1);
    chk("abort.err", err, 0);
    step();
    chk("abort.go_cen_once", GO_cen, 0);
    chk("abort.addr1", addr, 1);

    // reset in the middle of STORE
    wait_state(STORE, 100, "rst.reach_store");
    #2;
    rst = 1;
    #1;
    chk("rst.state", state, IDLE);
    chk("rst.ctrl", ctrl, ID);
    chk("rst.addr", addr, 0);
    step();
    rst = 0;
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      nd += int'(done);
      step();
    end
    chk("rst.no_done", nd, 0);
    go = 1;
    step();
    go = 0;
    k = 0;
    while (done !== 1'b1 && k < 200) begin
      step();
      k++;
    end
    chk("rst.rerun_done", done, 1);
    chk("rst.rerun_err", err, 0);
    step();
    chk("rst.rerun_idle", state, IDLE);

    // full-width sweep: no early wrap of the address
    go_big = 1;
    step();
    go_big = 0;
    k = 0;
    bad = 0;
    last = '0;
    while (b_state == CEN_LOAD && k < 20000) begin
      if (b_addr !== AW'(k)) bad++;
      last = b_addr;
      step();
      k++;
    end
    chk("big.len", k, 1 << AW);
    chk("big.last", last, (1 << AW) - 1);
    chk("big.no_wrap", bad, 0);
    chk("big.next", b_state, CEN_WAIT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
